// File: rtl/rom_image_loader.sv
// Byte-stream program loader: length header, 6-byte little-endian instruction
// words and an XOR checksum; each assembled word is written with an active-low strobe.
module rom_image_loader #(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  _reset,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [47:0]           mem_data,
  output logic                  _mem_we,
  output logic                  busy,
  output logic                  done,
  output logic                  checksum_err,
  output logic [15:0]           words_written
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LEN_LO = 3'd1;
  localparam logic [2:0] LEN_HI = 3'd2;
  localparam logic [2:0] BYTE   = 3'd3;
  localparam logic [2:0] WRITE  = 3'd4;
  localparam logic [2:0] CHECK  = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;

  logic [2:0]            state_q, state_d;
  logic                  in_ready_q, in_ready_d;
  logic                  mem_we_n_q, mem_we_n_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [47:0]           mem_data_q, mem_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [15:0]           words_q, words_d;
  logic [15:0]           len_q, len_d;
  logic [7:0]            acc_q, acc_d;
  logic [2:0]            lane_q, lane_d;
  logic                  accept;

  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    words_d    = words_q;
    len_d      = len_q;
    acc_d      = acc_q;
    lane_d     = lane_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = LEN_LO;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          err_d      = 1'b0;
          acc_d      = 8'h00;
          words_d    = 16'h0000;
          lane_d     = 3'd0;
          mem_addr_d = BASE_ADDR;
        end
      end
      LEN_LO: begin
        if (accept) begin
          len_d[7:0] = in_data;
          acc_d      = acc_q ^ in_data;
          state_d    = LEN_HI;
        end
      end
      LEN_HI: begin
        if (accept) begin
          len_d[15:8] = in_data;
          acc_d       = acc_q ^ in_data;
          lane_d      = 3'd0;
          state_d     = ({in_data, len_q[7:0]} == 16'h0000) ? CHECK : BYTE;
        end
      end
      BYTE: begin
        if (accept) begin
          mem_data_d[{lane_q, 3'b000} +: 8] = in_data;
          acc_d = acc_q ^ in_data;
          if (lane_q == 3'd5) begin
            lane_d  = 3'd0;
            state_d = WRITE;
          end else begin
            lane_d = lane_q + 3'd1;
          end
        end
      end
      WRITE: begin
        // Strobe rises at the end of this cycle; advance bookkeeping on that edge.
        words_d    = words_q + 16'd1;
        mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);
        lane_d     = 3'd0;
        state_d    = ((words_q + 16'd1) == len_q) ? CHECK : BYTE;
      end
      CHECK: begin
        if (accept) begin
          err_d   = (in_data != acc_q);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Handshake and strobe are registered decodes of the next state.
    in_ready_d = (state_d == LEN_LO) || (state_d == LEN_HI) ||
                 (state_d == BYTE)   || (state_d == CHECK);
    mem_we_n_d = (state_d != WRITE);
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
      mem_we_n_q <= 1'b1;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      words_q    <= '0;
      len_q      <= '0;
      acc_q      <= '0;
      lane_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      mem_we_n_q <= mem_we_n_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      words_q    <= words_d;
      len_q      <= len_d;
      acc_q      <= acc_d;
      lane_q     <= lane_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign mem_addr      = mem_addr_q;
  assign mem_data      = mem_data_q;
  assign _mem_we       = mem_we_n_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign checksum_err  = err_q;
  assign words_written = words_q;

endmodule

// File: tb/tb_rom_image_loader.sv
// Directed bench for rom_image_loader: two instances (base 0 and base 0xFFFF)
// share one stimulus stream so address wrap is exercised alongside the normal path.
module tb_rom_image_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;

  logic        rdy_a, we_a, busy_a, done_a, err_a;
  logic [15:0] addr_a, ww_a;
  logic [47:0] data_a;
  logic        rdy_b, we_b, busy_b, done_b, err_b;
  logic [15:0] addr_b, ww_b;
  logic [47:0] data_b;

  int          n_chk = 0;
  int          n_fail = 0;
  int          wr_a = 0;
  int          wr_b = 0;
  logic [7:0]  csum;

  rom_image_loader #(.ADDR_WIDTH(16), .BASE_ADDR(16'h0000)) ua (
    .clk(clk), ._reset(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_a), .mem_addr(addr_a), .mem_data(data_a), ._mem_we(we_a),
    .busy(busy_a), .done(done_a), .checksum_err(err_a), .words_written(ww_a));

  rom_image_loader #(.ADDR_WIDTH(16), .BASE_ADDR(16'hFFFF)) ub (
    .clk(clk), ._reset(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_b), .mem_addr(addr_b), .mem_data(data_b), ._mem_we(we_b),
    .busy(busy_b), .done(done_b), .checksum_err(err_b), .words_written(ww_b));

  always #5 clk = ~clk;

  // Strobe is low for exactly one full cycle per write, so one sample per cycle counts it once.
  always @(negedge clk) begin
    if (we_a === 1'b0) wr_a++;
    if (we_b === 1'b0) wr_b++;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap, input bit acc);
    int t;
    repeat (gap + 1) @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    if (acc) csum = csum ^ b;
    t = 0;
    while (rdy_a !== 1'b1 && t < 16) begin
      @(negedge clk);
      t++;
    end
    if (t == 16) begin
      check("ready_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic begin_load(input logic [15:0] len);
    pulse_start();
    check("busy_after_start", {63'd0, busy_a}, 64'd1);
    csum = 8'h00;
    send(len[7:0], 0, 1'b1);
    send(len[15:8], 0, 1'b1);
  endtask

  task automatic check_write(input logic [47:0] w, input logic [15:0] idx);
    logic [15:0] eb;
    eb = 16'hFFFF + idx;
    check("we_low_a", {63'd0, we_a}, 64'd0);
    check("we_low_b", {63'd0, we_b}, 64'd0);
    check("ready_in_write", {63'd0, rdy_a}, 64'd0);
    check("addr_a", {48'd0, addr_a}, {48'd0, idx});
    check("addr_b", {48'd0, addr_b}, {48'd0, eb});
    check("data_a", {16'd0, data_a}, {16'd0, w});
  endtask

  task automatic send_word(input logic [47:0] w, input int gap, input logic [15:0] idx);
    for (int k = 0; k < 6; k++) send(w[8*k +: 8], (k * gap) % 3, 1'b1);
    check_write(w, idx);
  endtask

  task automatic finish_load(input logic [7:0] cs, input bit exp_err, input logic [15:0] exp_ww,
                             input int exp_wr);
    send(cs, 0, 1'b0);
    check("done", {63'd0, done_a}, 64'd1);
    check("busy_at_done", {63'd0, busy_a}, 64'd0);
    check("checksum_err", {63'd0, err_a}, {63'd0, exp_err});
    check("words_written", {48'd0, ww_a}, {48'd0, exp_ww});
    check("write_count_a", 64'(wr_a), 64'(exp_wr));
    check("write_count_b", 64'(wr_b), 64'(exp_wr));
  endtask

  task automatic check_reset_values();
    check("rst_ready", {63'd0, rdy_a}, 64'd0);
    check("rst_we", {62'd0, we_a, we_b}, 64'd3);
    check("rst_addr", {32'd0, addr_a, addr_b}, 64'd0);
    check("rst_data", {16'd0, data_a}, 64'd0);
    check("rst_flags", {61'd0, busy_a, done_a, err_a}, 64'd0);
    check("rst_words", {48'd0, ww_a}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check_reset_values();
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_ready", {63'd0, rdy_a}, 64'd0);

    // single word, no stalls: checksum 01^00^11^22^33^44^55^66 = 0x76
    begin_load(16'd1);
    send_word(48'h665544332211, 0, 16'd0);
    check("csum_model", {56'd0, csum}, 64'h76);
    finish_load(8'h76, 1'b0, 16'd1, 1);

    // two words with in_valid gaps; instance b wraps 0xFFFF -> 0x0000
    begin_load(16'd2);
    send_word(48'hA6A5A4A3A2A1, 1, 16'd0);
    send_word(48'hB6B5B4B3B2B1, 2, 16'd1);
    finish_load(csum, 1'b0, 16'd2, 3);

    // zero length
    begin_load(16'd0);
    finish_load(8'h00, 1'b0, 16'd0, 3);

    // bad checksum still writes, then a new start clears done/err
    begin_load(16'd1);
    send_word(48'h665544332211, 0, 16'd0);
    finish_load(8'hFF, 1'b1, 16'd1, 4);
    pulse_start();
    check("restart_done_clr", {63'd0, done_a}, 64'd0);
    check("restart_err_clr", {63'd0, err_a}, 64'd0);
    check("restart_busy", {63'd0, busy_a}, 64'd1);

    // reset after 3 of 6 bytes: asynchronous clear, no write
    send(8'h01, 0, 1'b0);
    send(8'h00, 0, 1'b0);
    send(8'hC1, 0, 1'b0);
    send(8'hC2, 0, 1'b0);
    send(8'hC3, 0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values();
    repeat (2) @(negedge clk);
    check("no_write_on_reset", 64'(wr_a), 64'd4);
    rst_n = 1'b1;
    begin_load(16'd1);
    send_word(48'h0C0B0A090807, 0, 16'd0);
    finish_load(csum, 1'b0, 16'd1, 5);

    // start during BYTE is ignored
    begin_load(16'd1);
    send(8'hD1, 0, 1'b1);
    send(8'hD2, 0, 1'b1);
    pulse_start();
    check("ignored_start_busy", {63'd0, busy_a}, 64'd1);
    check("ignored_start_ready", {63'd0, rdy_a}, 64'd1);
    send(8'hD3, 0, 1'b1);
    send(8'hD4, 0, 1'b1);
    send(8'hD5, 0, 1'b1);
    send(8'hD6, 0, 1'b1);
    check_write(48'hD6D5D4D3D2D1, 16'd0);
    finish_load(csum, 1'b0, 16'd1, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
